frog_controller: RTL and testbench

//  Player-position engine: turns debounced button levels into one-tile frog moves on the lane grid.

---
 rtl/frogger_pkg.sv | 13 +
 rtl/frog_controller_btn_edge_detect.sv | 18 +
 rtl/frog_controller.sv | 148 ++++++++++++++
 tb/tb_frog_controller.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/frogger_pkg.sv
// frogger_pkg: game state encoding, lane-grid constants and the inclusive row-range helper
package frogger_pkg;
    localparam int GRID_COLS = 20;
    localparam int GRID_ROWS = 16;
    localparam logic [9:0] ROW_MAX = 10'(GRID_ROWS - 1);
    localparam logic [9:0] COL_MAX = 10'(GRID_COLS - 1);

    typedef enum logic [1:0] {PLAY, DEAD, ARRIVED, GAME_OVER} state_t;

    function automatic logic in_range(input logic [9:0] row, input logic [9:0] lo, input logic [9:0] hi);
        return (row >= lo) && (row <= hi);
    endfunction
endpackage

// File: rtl/frog_controller_btn_edge_detect.sv
// btn_edge_detect: 4-bit rising-edge detector on debounced button levels
module btn_edge_detect (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [3:0] i_Btn,
    output logic [3:0] o_Rise
);
    logic [3:0] r_prev;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst)
            r_prev <= '0;
        else
            r_prev <= i_Btn;
    end

    assign o_Rise = i_Btn & ~r_prev;
endmodule

// File: rtl/frog_controller.sv
// frog_controller: turns button edges into one-tile frog moves and sequences
// death, arrival, respawn and game-over on the lane grid.
module frog_controller
    import frogger_pkg::*;
#(
    parameter int SPAWN_COL   = 10,
    parameter int START_LIVES = 3,
    parameter int LEVEL_MAX   = 15,
    parameter int HOLD_CYCLES = 1_250_000
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Up,
    input  logic       i_Down,
    input  logic       i_Left,
    input  logic       i_Right,
    input  logic       i_Hit,
    input  logic [9:0] i_Arrival_Start,
    input  logic [9:0] i_Arrival_End,
    input  logic [9:0] i_Middle_Start,
    input  logic [9:0] i_Middle_End,
    input  logic [9:0] i_Spawn_Start,
    input  logic [9:0] i_Spawn_End,
    output logic [9:0] o_Frog_Row,
    output logic [9:0] o_Frog_Col,
    output logic [1:0] o_Lives,
    output logic [3:0] o_Level,
    output logic       o_On_Grass,
    output logic       o_Win_Pulse,
    output logic       o_Death_Pulse,
    output logic       o_Game_Over
);
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [9:0] SPAWN_C = 10'(SPAWN_COL);
    localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);
    localparam logic [3:0] LVL_SAT = 4'(LEVEL_MAX);

    state_t           r_state, w_state;
    logic [9:0]       r_row, r_col, w_row, w_col, w_mv_row, w_mv_col;
    logic [1:0]       r_lives, w_lives;
    logic [3:0]       r_level, w_level;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic             r_on_grass, r_win, r_death, w_win, w_death;
    logic [3:0]       w_rise;

    btn_edge_detect u_edge (
        .i_Clk  (i_Clk),
        .i_Rst  (i_Rst),
        .i_Btn  ({i_Right, i_Left, i_Down, i_Up}),
        .o_Rise (w_rise)
    );

    // Strict Up>Down>Left>Right priority: the winning edge is clamped, never replaced by a lower one
    always_comb begin
        w_mv_row = r_row;
        w_mv_col = r_col;
        if (w_rise[0])
            w_mv_row = (r_row == '0) ? r_row : r_row - 10'd1;
        else if (w_rise[1])
            w_mv_row = (r_row == ROW_MAX) ? r_row : r_row + 10'd1;
        else if (w_rise[2])
            w_mv_col = (r_col == '0) ? r_col : r_col - 10'd1;
        else if (w_rise[3])
            w_mv_col = (r_col == COL_MAX) ? r_col : r_col + 10'd1;
    end

    always_comb begin
        w_state = r_state;
        w_row   = r_row;
        w_col   = r_col;
        w_lives = r_lives;
        w_level = r_level;
        w_cnt   = '0;
        w_win   = 1'b0;
        w_death = 1'b0;
        case (r_state)
            PLAY: begin
                if (i_Hit && !r_on_grass) begin
                    w_death = 1'b1;
                    w_lives = r_lives - 2'd1;
                    w_state = (r_lives == 2'd1) ? GAME_OVER : DEAD;
                end else if (|w_rise) begin
                    w_row = w_mv_row;
                    w_col = w_mv_col;
                    if (in_range(w_mv_row, i_Arrival_Start, i_Arrival_End)) begin
                        w_win   = 1'b1;
                        w_level = (r_level >= LVL_SAT) ? r_level : r_level + 4'd1;
                        w_state = ARRIVED;
                    end
                end
            end
            DEAD, ARRIVED: begin
                if (r_cnt == HOLD_LAST) begin
                    w_row   = i_Spawn_End;
                    w_col   = SPAWN_C;
                    w_state = PLAY;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                if (|w_rise) begin
                    w_lives = LIVES_INIT;
                    w_level = '0;
                    w_row   = i_Spawn_End;
                    w_col   = SPAWN_C;
                    w_state = PLAY;
                end
            end
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_state    <= PLAY;
            r_row      <= i_Spawn_End;
            r_col      <= SPAWN_C;
            r_lives    <= LIVES_INIT;
            r_level    <= '0;
            r_cnt      <= '0;
            r_win      <= 1'b0;
            r_death    <= 1'b0;
            r_on_grass <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_row      <= w_row;
            r_col      <= w_col;
            r_lives    <= w_lives;
            r_level    <= w_level;
            r_cnt      <= w_cnt;
            r_win      <= w_win;
            r_death    <= w_death;
            r_on_grass <= in_range(r_row, i_Arrival_Start, i_Arrival_End) ||
                          in_range(r_row, i_Middle_Start, i_Middle_End) ||
                          in_range(r_row, i_Spawn_Start, i_Spawn_End);
        end
    end

    assign o_Frog_Row    = r_row;
    assign o_Frog_Col    = r_col;
    assign o_Lives       = r_lives;
    assign o_Level       = r_level;
    assign o_On_Grass    = r_on_grass;
    assign o_Win_Pulse   = r_win;
    assign o_Death_Pulse = r_death;
    assign o_Game_Over   = (r_state == GAME_OVER);
endmodule

// File: tb/tb_frog_controller.sv
// tb_frog_controller: directed scenarios plus random play, checked against a behavioural game model
module tb_frog_controller;
    localparam int HOLD = 8;
    localparam int A_LO = 0, A_HI = 2, M_LO = 8, M_HI = 9, S_LO = 14, S_HI = 15;
    localparam logic [3:0] UP = 4'b0001, DN = 4'b0010, LF = 4'b0100, RT = 4'b1000, NB = 4'b0000;

    logic clk = 1'b0, rst = 1'b1;
    logic up = 0, down = 0, left = 0, right = 0, hit = 0;
    logic [9:0] frog_row, frog_col;
    logic [1:0] lives;
    logic [3:0] level;
    logic on_grass, win_p, death_p, game_over;

    int n_cmp = 0, n_bad = 0;

    // model: mode 0 = playing, 1 = frozen hold, 2 = game over
    int m_row, m_col, m_lives, m_level, m_mode, m_hold;
    logic m_grass, m_win, m_death;
    logic [3:0] m_prev;

    always #5 clk = ~clk;

    frog_controller #(.HOLD_CYCLES(HOLD)) dut (
        .i_Clk(clk), .i_Rst(rst),
        .i_Up(up), .i_Down(down), .i_Left(left), .i_Right(right), .i_Hit(hit),
        .i_Arrival_Start(10'(A_LO)), .i_Arrival_End(10'(A_HI)),
        .i_Middle_Start(10'(M_LO)), .i_Middle_End(10'(M_HI)),
        .i_Spawn_Start(10'(S_LO)), .i_Spawn_End(10'(S_HI)),
        .o_Frog_Row(frog_row), .o_Frog_Col(frog_col), .o_Lives(lives), .o_Level(level),
        .o_On_Grass(on_grass), .o_Win_Pulse(win_p), .o_Death_Pulse(death_p), .o_Game_Over(game_over)
    );

    function automatic logic grass_row(input int r);
        return (r >= A_LO && r <= A_HI) || (r >= M_LO && r <= M_HI) || (r >= S_LO && r <= S_HI);
    endfunction

    function automatic logic [29:0] dut_vec();
        return {frog_row, frog_col, lives, level, on_grass, win_p, death_p, game_over};
    endfunction

    function automatic logic [29:0] mdl_vec();
        return {10'(m_row), 10'(m_col), 2'(m_lives), 4'(m_level), m_grass, m_win, m_death, m_mode == 2};
    endfunction

    task automatic model_reset();
        m_row = S_HI; m_col = 10; m_lives = 3; m_level = 0; m_mode = 0; m_hold = 0;
        m_grass = 0; m_win = 0; m_death = 0; m_prev = '0;
    endtask

    task automatic model_step(input logic [3:0] btn, input logic h);
        logic [3:0] rise;
        int old_row;
        rise = btn & ~m_prev;
        old_row = m_row;
        m_win = 0;
        m_death = 0;
        if (m_mode == 0) begin
            if (h && !m_grass) begin
                m_death = 1;
                m_lives = m_lives - 1;
                if (m_lives == 0) m_mode = 2;
                else begin m_mode = 1; m_hold = HOLD; end
            end else if (rise != 0) begin
                if (rise[0]) m_row = (m_row > 0) ? m_row - 1 : m_row;
                else if (rise[1]) m_row = (m_row < 15) ? m_row + 1 : m_row;
                else if (rise[2]) m_col = (m_col > 0) ? m_col - 1 : m_col;
                else m_col = (m_col < 19) ? m_col + 1 : m_col;
                if (m_row >= A_LO && m_row <= A_HI) begin
                    m_win = 1;
                    m_level = (m_level < 15) ? m_level + 1 : 15;
                    m_mode = 1;
                    m_hold = HOLD;
                end
            end
        end else if (m_mode == 1) begin
            m_hold = m_hold - 1;
            if (m_hold == 0) begin m_row = S_HI; m_col = 10; m_mode = 0; end
        end else if (rise != 0) begin
            m_lives = 3; m_level = 0; m_row = S_HI; m_col = 10; m_mode = 0;
        end
        m_grass = grass_row(old_row);
        m_prev = btn;
    endtask

    task automatic tick(input logic [3:0] b, input logic h);
        {right, left, down, up} = b;
        hit = h;
        model_step(b, h);
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            tick(b, 0);
            tick(NB, 0);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (dut_vec() !== {10'd15, 10'd10, 2'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL reset_state got=%h want=%h", dut_vec(), {10'd15, 10'd10, 2'd3, 4'd0, 4'd0});
        end
        rst = 0;
        model_reset();
        tick(NB, 0);
        n_cmp++;
        if (on_grass !== 1'b1) begin n_bad++; $display("FAIL reset_grass got=%b want=1", on_grass); end
    endtask

    task automatic test_hold_once();
        repeat (20) tick(UP, 0);
        n_cmp++;
        if (frog_row !== 10'd14) begin n_bad++; $display("FAIL hold_once row=%0d want=14", frog_row); end
        tick(NB, 0);
        tick(UP, 0);
        n_cmp++;
        if (frog_row !== 10'd13) begin n_bad++; $display("FAIL second_press row=%0d want=13", frog_row); end
        tick(NB, 0);
    endtask

    task automatic test_priority_clamp();
        press(DN, 1);
        tick(UP | LF, 0);
        n_cmp++;
        if ({frog_row, frog_col} !== {10'd13, 10'd10}) begin
            n_bad++; $display("FAIL up_left_priority pos=(%0d,%0d) want=(13,10)", frog_row, frog_col);
        end
        tick(NB, 0);
        press(LF, 11);
        n_cmp++;
        if (frog_col !== 10'd0) begin n_bad++; $display("FAIL left_clamp col=%0d want=0", frog_col); end
        press(DN, 3);
        n_cmp++;
        if (frog_row !== 10'd15) begin n_bad++; $display("FAIL down_clamp row=%0d want=15", frog_row); end
        press(RT, 20);
        n_cmp++;
        if (frog_col !== 10'd19) begin n_bad++; $display("FAIL right_clamp col=%0d want=19", frog_col); end
        n_cmp++;
        if (dut_vec() !== mdl_vec()) begin n_bad++; $display("FAIL clamp_model got=%h want=%h", dut_vec(), mdl_vec()); end
    endtask

    task automatic test_arrival();
        press(UP, 12);
        n_cmp++;
        if (frog_row !== 10'd3 || level !== 4'd0) begin
            n_bad++; $display("FAIL pre_arrival row=%0d level=%0d want=3,0", frog_row, level);
        end
        tick(UP, 0);
        n_cmp++;
        if ({frog_row, win_p, level} !== {10'd2, 1'b1, 4'd1}) begin
            n_bad++; $display("FAIL arrival row=%0d win=%b level=%0d want=2,1,1", frog_row, win_p, level);
        end
        tick(DN, 0);
        n_cmp++;
        if (win_p !== 1'b0 || frog_row !== 10'd2) begin
            n_bad++; $display("FAIL win_one_cycle win=%b row=%0d want=0,2", win_p, frog_row);
        end
        repeat (6) tick(NB, 0);
        n_cmp++;
        if (frog_row !== 10'd2) begin n_bad++; $display("FAIL arrived_frozen row=%0d want=2", frog_row); end
        tick(NB, 0);
        n_cmp++;
        if ({frog_row, frog_col} !== {10'd15, 10'd10}) begin
            n_bad++; $display("FAIL arrival_respawn pos=(%0d,%0d) want=(15,10)", frog_row, frog_col);
        end
    endtask

    task automatic test_hit();
        press(UP, 10);
        tick(NB, 1);
        n_cmp++;
        if ({death_p, lives} !== {1'b1, 2'd2}) begin
            n_bad++; $display("FAIL road_hit death=%b lives=%0d want=1,2", death_p, lives);
        end
        tick(NB, 0);
        n_cmp++;
        if (death_p !== 1'b0) begin n_bad++; $display("FAIL death_one_cycle death=%b want=0", death_p); end
        repeat (7) tick(NB, 0);
        n_cmp++;
        if ({frog_row, frog_col} !== {10'd15, 10'd10}) begin
            n_bad++; $display("FAIL death_respawn pos=(%0d,%0d) want=(15,10)", frog_row, frog_col);
        end
        press(UP, 7);
        tick(NB, 1);
        n_cmp++;
        if ({frog_row, death_p, lives} !== {10'd8, 1'b0, 2'd2}) begin
            n_bad++; $display("FAIL grass_safe row=%0d death=%b lives=%0d want=8,0,2", frog_row, death_p, lives);
        end
    endtask

    task automatic test_game_over();
        press(UP, 1);
        tick(NB, 1);
        repeat (HOLD) tick(NB, 0);
        press(UP, 2);
        tick(NB, 1);
        n_cmp++;
        if ({lives, game_over, death_p} !== {2'd0, 1'b1, 1'b1}) begin
            n_bad++; $display("FAIL game_over lives=%0d over=%b death=%b want=0,1,1", lives, game_over, death_p);
        end
        tick(NB, 1);
        n_cmp++;
        if ({lives, game_over, frog_row} !== {2'd0, 1'b1, 10'd13}) begin
            n_bad++; $display("FAIL over_frozen lives=%0d over=%b row=%0d want=0,1,13", lives, game_over, frog_row);
        end
        tick(RT, 0);
        n_cmp++;
        if (dut_vec() !== {10'd15, 10'd10, 2'd3, 4'd0, 1'b0, 3'b000}) begin
            n_bad++; $display("FAIL restart got=%h want=%h", dut_vec(), {10'd15, 10'd10, 2'd3, 4'd0, 4'd0});
        end
        tick(NB, 0);
    endtask

    task automatic test_reset_mid_hold();
        press(UP, 2);
        tick(NB, 1);
        repeat (3) tick(NB, 0);
        rst = 1;
        #1;
        n_cmp++;
        if ({frog_row, frog_col, lives, level, win_p, death_p, game_over} !== {10'd15, 10'd10, 2'd3, 4'd0, 3'b000}) begin
            n_bad++; $display("FAIL async_reset row=%0d col=%0d lives=%0d level=%0d", frog_row, frog_col, lives, level);
        end
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        tick(UP, 0);
        n_cmp++;
        if (frog_row !== 10'd14) begin n_bad++; $display("FAIL play_after_reset row=%0d want=14", frog_row); end
        tick(NB, 0);
    endtask

    task automatic test_random();
        logic [3:0] b;
        b = '0;
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < 4; k++)
                if ($urandom_range(3) == 0) b[k] = ~b[k];
            tick(b, $urandom_range(9) == 0);
            n_cmp++;
            if (dut_vec() !== mdl_vec()) begin
                n_bad++; $display("FAIL random cycle=%0d got=%h want=%h", i, dut_vec(), mdl_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_hold_once();
        test_priority_clamp();
        test_arrival();
        test_hit();
        test_game_over();
        test_reset_mid_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
